// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues SRAM-like bus requests, buffers returned words in a
// small in-order slot ring feeding ID, and discards in-flight responses after a redirect.
module if_fetch_buffer #(
    parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
    parameter int          IBUF_DEPTH = 2,
    parameter int          CNT_W      = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allowin,
    output logic        if_id_valid,
    output logic [64:0] if_id_bus,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic        alloc;
        logic        filled;
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } slot_t;

    slot_t       slot_q [IBUF_DEPTH];
    slot_t       slot_d [IBUF_DEPTH];
    ptr_t        head_q, head_d, tail_q, tail_d, fill_ptr_q, fill_ptr_d;
    cnt_t        used_q, used_d, cancel_cnt_q, cancel_cnt_d, unfilled;
    logic [31:0] fetch_pc_q, fetch_pc_d, hold_addr_q, hold_addr_d, redirect_pc;
    logic        stale_q, stale_d, hold_q, hold_d, adef_stall_q, adef_stall_d;
    logic        redirect, not_full, pc_aligned, issue_new, accept;
    logic        alloc_fetch, alloc_adef, drop, fill, pop;

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;

    always_comb begin : control
        redirect = wb_ex | br_taken | ertn_flush;
        if (wb_ex)         redirect_pc = ex_entry;
        else if (br_taken) redirect_pc = br_target;
        else               redirect_pc = ertn_entry;

        not_full   = used_q < cnt_t'(IBUF_DEPTH);
        pc_aligned = fetch_pc_q[1:0] == 2'b00;
        issue_new  = not_full & pc_aligned & ~redirect & ~stale_q & ~adef_stall_q;
        // A request left hanging without addr_ok must be held, even through a redirect.
        inst_req   = resetn & (hold_q | issue_new);
        inst_addr  = hold_q ? hold_addr_q : fetch_pc_q;

        accept      = inst_req & inst_addr_ok;
        alloc_fetch = accept & ~stale_q & ~redirect;
        alloc_adef  = not_full & ~pc_aligned & ~redirect & ~hold_q & ~adef_stall_q;
        drop        = inst_data_ok & (cancel_cnt_q != '0);
        fill        = inst_data_ok & ~drop & slot_q[fill_ptr_q].alloc & ~slot_q[fill_ptr_q].filled;

        if_id_valid = slot_q[head_q].alloc & slot_q[head_q].filled & ~redirect;
        if_id_bus   = {slot_q[head_q].pc, slot_q[head_q].inst, slot_q[head_q].adef};
        pop         = if_id_valid & id_allowin;

        unfilled = '0;
        for (int i = 0; i < IBUF_DEPTH; i++) begin
            unfilled = unfilled + cnt_t'(slot_q[i].alloc & ~slot_q[i].filled);
        end
    end

    always_comb begin : next_state
        // NOTE: every next-state variable takes its current value first, so no path infers a latch.
        slot_d       = slot_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_ptr_d   = fill_ptr_q;
        used_d       = used_q;
        fetch_pc_d   = fetch_pc_q;
        adef_stall_d = adef_stall_q;
        cancel_cnt_d = cancel_cnt_q - cnt_t'(drop);
        stale_d      = stale_q & ~accept;
        hold_d       = inst_req & ~inst_addr_ok;
        hold_addr_d  = inst_addr;

        if (redirect) begin
            // Everything still owed by the bus for the old stream must be swallowed later.
            cancel_cnt_d = cancel_cnt_d + unfilled - cnt_t'(fill) + cnt_t'(accept);
            stale_d      = inst_req & ~inst_addr_ok;
            fetch_pc_d   = redirect_pc;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                slot_d[i].alloc  = 1'b0;
                slot_d[i].filled = 1'b0;
            end
            head_d       = '0;
            tail_d       = '0;
            fill_ptr_d   = '0;
            used_d       = '0;
            adef_stall_d = 1'b0;
        end else begin
            if (stale_q & accept) begin
                cancel_cnt_d = cancel_cnt_d + cnt_t'(1);
            end
            if (fill) begin
                slot_d[fill_ptr_q].inst   = inst_rdata;
                slot_d[fill_ptr_q].adef   = 1'b0;
                slot_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d = fill_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                slot_d[head_q].alloc  = 1'b0;
                slot_d[head_q].filled = 1'b0;
                head_d = head_q + ptr_t'(1);
            end
            if (alloc_fetch) begin
                slot_d[tail_q] = '{alloc: 1'b1, filled: 1'b0, adef: 1'b0, pc: inst_addr, inst: 32'h0};
                tail_d     = tail_q + ptr_t'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (alloc_adef) begin
                slot_d[tail_q] = '{alloc: 1'b1, filled: 1'b1, adef: 1'b1, pc: fetch_pc_q, inst: 32'h0};
                tail_d       = tail_q + ptr_t'(1);
                adef_stall_d = 1'b1;
            end
            used_d = used_q + cnt_t'(alloc_fetch | alloc_adef) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (!resetn) begin
            // NOTE: slot contents are reset too, since if_id_bus must read zero out of reset.
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            fill_ptr_q   <= '0;
            used_q       <= '0;
            cancel_cnt_q <= '0;
            fetch_pc_q   <= RESET_PC;
            hold_addr_q  <= '0;
            stale_q      <= 1'b0;
            hold_q       <= 1'b0;
            adef_stall_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            slot_q       <= slot_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_ptr_q   <= fill_ptr_d;
            used_q       <= used_d;
            cancel_cnt_q <= cancel_cnt_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_addr_q  <= hold_addr_d;
            stale_q      <= stale_d;
            hold_q       <= hold_d;
            adef_stall_q <= adef_stall_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: an in-order bus partner plus a stream-level model
// of what ID must see (pc sequence from the last redirect target, word = f(pc)).
module tb_if_fetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          DEPTH    = 2;

    logic        clk, resetn, id_allowin;
    logic        if_id_valid;
    logic [64:0] if_id_bus;
    logic        br_taken, wb_ex, ertn_flush;
    logic [31:0] br_target, ex_entry, ertn_entry;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit bus_addr_ok_en = 1'b1;
    int bus_lat        = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q [$];
    logic [31:0] acc_log [$];
    logic [64:0] del_log [$];

    int          n0, a0;
    logic [64:0] d;

    if_fetch_buffer #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn), .id_allowin(id_allowin),
        .if_id_valid(if_id_valid), .if_id_bus(if_id_bus),
        .br_taken(br_taken), .br_target(br_target),
        .wb_ex(wb_ex), .ex_entry(ex_entry),
        .ertn_flush(ertn_flush), .ertn_entry(ertn_entry),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hffff_ffff;
    endfunction

    function automatic logic [64:0] del_at(input int i);
        if (i < del_log.size()) return del_log[i];
        return '1;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus partner: in-order, fixed latency, reset by the same resetn.
    initial begin : bus_partner
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (!resetn) begin
                pend_q.delete();
                inst_addr_ok = 1'b0;
                inst_data_ok = 1'b0;
                inst_rdata   = 32'h0;
            end else begin
                inst_addr_ok = bus_addr_ok_en;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(pend_q[0].addr);
                end else begin
                    inst_data_ok = 1'b0;
                    inst_rdata   = 32'hdead_beef;
                end
            end
            #3;
            if (resetn) begin
                if (inst_data_ok) void'(pend_q.pop_front());
                if (inst_req && inst_addr_ok) begin
                    pend_q.push_back('{inst_addr, cyc + bus_lat});
                    acc_log.push_back(inst_addr);
                end
            end
        end
    end

    // Stream model: ID sees target, target+4, ... after each redirect; a misaligned pc
    // yields one adef entry and nothing afterwards.
    initial begin : compare
        logic [31:0] exp_pc, prev_addr;
        logic        exp_adef, adef_seen, prev_hold;
        exp_pc    = RESET_PC;
        adef_seen = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!resetn) begin
                exp_pc    = RESET_PC;
                adef_seen = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("req_held", inst_req, 1'b1);
                    check("addr_held", inst_addr, prev_addr);
                end
                check("used_bound", dut.used_q <= DEPTH, 1'b1);
                check("cancel_bound", dut.cancel_cnt_q <= DEPTH + 1, 1'b1);
                if (wb_ex || br_taken || ertn_flush) begin
                    check("valid_on_redirect", if_id_valid, 1'b0);
                    exp_pc    = wb_ex ? ex_entry : (br_taken ? br_target : ertn_entry);
                    adef_seen = 1'b0;
                end else if (if_id_valid) begin
                    exp_adef = exp_pc[1:0] != 2'b00;
                    check("id_bus", if_id_bus, {exp_pc, exp_adef ? 32'h0 : mem_word(exp_pc), exp_adef});
                    check("no_fetch_after_adef", adef_seen, 1'b0);
                    if (id_allowin) begin
                        del_log.push_back(if_id_bus);
                        exp_pc    = exp_pc + 32'd4;
                        adef_seen = exp_adef;
                    end
                end
                prev_hold = inst_req & ~inst_addr_ok;
                prev_addr = inst_addr;
            end
        end
    end

    task automatic do_reset();
        resetn     = 1'b0;
        br_taken   = 1'b0;
        wb_ex      = 1'b0;
        ertn_flush = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_bus", if_id_bus, 65'h0);
        check("rst_req", inst_req, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        acc_log.delete();
        del_log.delete();
    endtask

    task automatic wait_del(input int n, input int budget, input string name);
        int k = 0;
        while (del_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, del_log.size() >= n, 1'b1);
    endtask

    // Called at a negedge; holds the redirect inputs for exactly one cycle.
    task automatic pulse_redirect(input logic ex, input logic br, input logic er,
                                  input logic [31:0] ex_a, input logic [31:0] br_a,
                                  input logic [31:0] er_a);
        wb_ex = ex; br_taken = br; ertn_flush = er;
        ex_entry = ex_a; br_target = br_a; ertn_entry = er_a;
        @(negedge clk);
        wb_ex = 1'b0; br_taken = 1'b0; ertn_flush = 1'b0;
    endtask

    initial begin : stimulus
        int k;
        resetn = 1'b0; id_allowin = 1'b1;
        br_taken = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
        br_target = '0; ex_entry = '0; ertn_entry = '0;

        // Streaming fetch after reset.
        bus_addr_ok_en = 1'b1; bus_lat = 1;
        do_reset();
        #4;
        check("first_req", inst_req, 1'b1);
        check("first_addr", inst_addr, RESET_PC);
        check("inst_wr", inst_wr, 1'b0);
        check("inst_size", inst_size, 2'b10);
        check("inst_wdata", inst_wdata, 32'h0);
        @(negedge clk);
        wait_del(3, 40, "t1_delivered");
        check("t1_addr0", acc_at(0), 32'h1c00_0000);
        check("t1_addr1", acc_at(1), 32'h1c00_0004);
        check("t1_addr2", acc_at(2), 32'h1c00_0008);
        check("t1_del0", del_at(0), {32'h1c00_0000, 32'h0000_ffff, 1'b0});
        check("t1_del1", del_at(1), {32'h1c00_0004, 32'h0004_fffb, 1'b0});
        d = del_at(2);
        check("t1_del2_pc", d[64:33], 32'h1c00_0008);

        // ID stalled: the ring fills with exactly DEPTH fetches.
        @(negedge clk);
        id_allowin = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        #4;
        check("t2_accepts", acc_log.size(), DEPTH);
        check("t2_req_full", inst_req, 1'b0);
        @(negedge clk);
        id_allowin = 1'b1;
        wait_del(2, 20, "t2_delivered");
        d = del_at(0);
        check("t2_del0_pc", d[64:33], 32'h1c00_0000);
        d = del_at(1);
        check("t2_del1_pc", d[64:33], 32'h1c00_0004);

        // Branch with two fetches in flight: both responses are cancelled.
        @(negedge clk);
        bus_lat = 6;
        do_reset();
        k = 0;
        while (acc_log.size() < 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_two_inflight", acc_log.size(), 2);
        pulse_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h1c00_0100, 32'h0);
        #4;
        check("t3_cancel2", dut.cancel_cnt_q, 3'd2);
        @(negedge clk);
        wait_del(1, 40, "t3_delivered");
        d = del_at(0);
        check("t3_del0_pc", d[64:33], 32'h1c00_0100);
        check("t3_cancel0", dut.cancel_cnt_q, 3'd0);
        check("t3_next_addr", acc_at(2), 32'h1c00_0100);

        // Exception while a request waits for addr_ok: request held, its data dropped.
        @(negedge clk);
        bus_lat = 1; bus_addr_ok_en = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        pulse_redirect(1'b1, 1'b0, 1'b0, 32'h1c00_8000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #4;
        check("t4_req_stable", inst_req, 1'b1);
        check("t4_addr_stable", inst_addr, 32'h1c00_0000);
        @(negedge clk);
        bus_addr_ok_en = 1'b1;
        wait_del(1, 30, "t4_delivered");
        check("t4_stale_addr", acc_at(0), 32'h1c00_0000);
        check("t4_next_addr", acc_at(1), 32'h1c00_8000);
        d = del_at(0);
        check("t4_del0_pc", d[64:33], 32'h1c00_8000);

        // All three redirects at once: exception wins.
        @(negedge clk);
        do_reset();
        repeat (4) @(negedge clk);
        a0 = acc_log.size();
        wb_ex = 1'b1; br_taken = 1'b1; ertn_flush = 1'b1;
        ex_entry = 32'h1c00_2000; br_target = 32'h1c00_3000; ertn_entry = 32'h1c00_4000;
        #4;
        check("t5_valid_low", if_id_valid, 1'b0);
        @(negedge clk);
        wb_ex = 1'b0; br_taken = 1'b0; ertn_flush = 1'b0;
        n0 = del_log.size();
        wait_del(n0 + 1, 30, "t5_delivered");
        d = del_at(n0);
        check("t5_del_pc", d[64:33], 32'h1c00_2000);
        check("t5_next_addr", acc_at(a0), 32'h1c00_2000);

        // Misaligned branch target: one adef entry, fetch stalls until the next redirect.
        @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);
        a0 = acc_log.size();
        pulse_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h1c00_0102, 32'h0);
        n0 = del_log.size();
        wait_del(n0 + 1, 20, "t6_adef_delivered");
        check("t6_adef_entry", del_at(n0), {32'h1c00_0102, 32'h0, 1'b1});
        repeat (8) @(negedge clk);
        check("t6_no_fetch", acc_log.size(), a0);
        check("t6_no_more_del", del_log.size(), n0 + 1);
        pulse_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h1c00_0200, 32'h0);
        wait_del(n0 + 2, 30, "t6_resumed");
        d = del_at(n0 + 1);
        check("t6_resume_pc", d[64:33], 32'h1c00_0200);
        check("t6_resume_addr", acc_at(a0), 32'h1c00_0200);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Next-generation instruction-fetch stage for the 5-stage LoongArch pipeline, between the instruction SRAM-like bus and ID.
- Replaces the fixed-latency SRAM fetch with a request/response interface (addr_ok/data_ok) and keeps up to IBUF_DEPTH requests in flight or buffered.
- Handles redirects (exception, branch, ertn) by flushing buffered instructions and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- IBUF_DEPTH, 2, number of slots: outstanding plus returned-but-unconsumed fetches (power of 2, 2..8).
- CNT_W, 3, width of slot/cancel counters; must satisfy 2^CNT_W > IBUF_DEPTH.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- id_allowin  in  1  ID can accept an instruction this cycle.
- if_id_valid  out  1  head slot delivered to ID.
- if_id_bus  out  65  {pc[31:0], inst[31:0], adef}.
- br_taken  in  1  branch redirect from ID.
- br_target  in  32  branch target.
- wb_ex  in  1  exception redirect from WB.
- ex_entry  in  32  exception entry.
- ertn_flush  in  1  ertn redirect from WB.
- ertn_entry  in  32  ertn return address.
- inst_req  out  1  bus request.
- inst_wr  out  1  constant 0.
- inst_size  out  2  constant 2'b10 (word).
- inst_addr  out  32  request address.
- inst_wdata  out  32  constant 0.
- inst_addr_ok  in  1  request accepted this cycle when inst_req=1.
- inst_data_ok  in  1  response returned this cycle, in request order.
- inst_rdata  in  32  response data.

Behaviour:
- Reset, synchronous:
  - fetch_pc=RESET_PC; inst_req=0; if_id_valid=0; if_id_bus=0.
  - All slots empty; cancel_cnt=0; stale=0.
- Redirect:
  - redirect = wb_ex | br_taken | ertn_flush.
  - Target priority: wb_ex > br_taken > ertn_flush.
  - Next cycle: fetch_pc=target; all slots freed.
- Slot ring:
  - Each slot holds {pc, inst, adef, filled}.
  - Slots are allocated in order at the tail and consumed at the head.
  - used = number of allocated slots, in range 0..IBUF_DEPTH.
- Issue:
  - inst_req=1 when used<IBUF_DEPTH, no redirect this cycle, and fetch_pc[1:0]==0; inst_addr=fetch_pc.
  - Once inst_req=1 and addr_ok=0, inst_req and inst_addr stay stable until addr_ok, even across a redirect.
- Accept (req & addr_ok, not stale, no redirect same cycle):
  - Allocate a tail slot {pc=fetch_pc, filled=0}.
  - fetch_pc += 4.
- ADEF: if fetch_pc[1:0]!=0 and used<IBUF_DEPTH, no bus request is issued.
  - A tail slot is allocated {pc, inst=0, adef=1, filled=1}.
  - Fetching stalls (fetch_pc unchanged, no further allocation) until a redirect.
- Response (data_ok):
  - If cancel_cnt>0: decrement cancel_cnt and drop the data.
  - Otherwise fill the oldest unfilled slot with inst_rdata, adef=0.
- Output:
  - if_id_valid = head slot filled & ~redirect.
  - if_id_bus comes from the head slot.
  - Pop the head when if_id_valid & id_allowin.
  - Data may reach ID no earlier than the cycle after data_ok (registered path).
- Redirect bookkeeping, in the redirect cycle:
  - Add to cancel_cnt: allocated-unfilled slots, minus 1 if a non-cancelled data_ok fills one this cycle, plus 1 if addr_ok accepts a request this cycle.
  - If inst_req=1 and addr_ok=0, set stale=1.
  - A later addr_ok while stale=1 does three things: cancel_cnt+=1, stale cleared, no slot allocated.
  - No new request is issued while stale=1.
- Simultaneous events:
  - Pop and fill in the same cycle are both honoured.
  - Accept and pop with used==IBUF_DEPTH: the accept is impossible, since req=0 when full.
  - Back-to-back redirects accumulate cancel_cnt correctly.
- Reset during an outstanding transaction clears all state; the bus partner is reset by the same resetn.
- Counters never wrap. Bench asserts:
  - cancel_cnt ≤ IBUF_DEPTH+1.
  - used ≤ IBUF_DEPTH.

Test Plan:
- Reset, then addr_ok=1 and data_ok one cycle after each accept, id_allowin=1 -> inst_addr sequence 1c000000, 1c000004, 1c000008; ID receives matching pc/inst in order, adef=0.
- id_allowin=0, bus zero-latency -> exactly IBUF_DEPTH=2 requests accepted, then inst_req=0; on id_allowin=1 both are delivered in order with no loss.
- Two requests outstanding, br_taken=1 with br_target=1c000100 -> both later responses dropped (cancel_cnt 2 to 0); next delivered pc=1c000100.
- inst_req held with addr_ok=0, wb_ex=1 with ex_entry=1c008000 -> inst_addr unchanged until addr_ok; that response is dropped; next request address is 1c008000.
- wb_ex, br_taken and ertn_flush all asserted together -> fetch_pc=ex_entry; if_id_valid=0 that cycle.
- br_target=1c000102 -> no bus request issued; ID receives pc=1c000102, adef=1, inst=0; fetch stalls until the next redirect.
